pixel_fb_writer: RTL

//  Receiving end of the draw controller's pixel-plot stream (plot strobe + x/y/colour).
//  - Range-checks each pixel and converts (x,y) to a linear framebuffer address (y*320+x).
//  - Buffers pixels in a FIFO and drains them to the framebuffer write port under fb_ready backpressure.
//  - On frame end, flushes the FIFO and signals completion back to the game FSM.

---
 rtl/pixel_pkg.sv | 36 +++
 rtl/pixel_fb_writer_if.sv | 22 ++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/pixel_fb_writer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel framebuffer writer.
// Contents:
//   SCREEN_W/SCREEN_H : visible screen size in pixels
//   X_W/Y_W/COL_W     : widths of the incoming pixel fields
//   ADDR_W            : width of the linear framebuffer address
//   fb_entry_t        : one buffered framebuffer write {addr, colour}
//   fsm_state_t       : frame flush controller states
//   lin_addr()        : y*320+x built from shifts (y*256 + y*64 + x)
package pixel_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COL_W    = 3;
  localparam int ADDR_W   = 17;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour;
  } fb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  // 320 = 256 + 64, so the multiply collapses to two shifted copies of y.
  // Largest result is 239*320+319 = 76799, which fits in 17 bits.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] px,
                                                 input logic [Y_W-1:0] py);
    lin_addr = {1'b0, py, 8'b0} + {3'b0, py, 6'b0} + {8'b0, px};
  endfunction

endpackage

// File: rtl/pixel_fb_writer_if.sv
// Framebuffer write port.
// Handshake: fb_wr_en is the valid and fb_ready is the ready. A write
// transfers on every rising clock edge where both are high. While fb_wr_en
// is high and fb_ready is low, fb_addr/fb_data hold their values. fb_wr_en
// never drops until the write has transferred.
// Signals:
//   fb_wr_en : write request (writer -> framebuffer)
//   fb_addr  : linear pixel address (writer -> framebuffer)
//   fb_data  : pixel colour (writer -> framebuffer)
//   fb_ready : framebuffer accepts a write this cycle (framebuffer -> writer)
// Modports: master = writer side, slave = framebuffer side.
interface pixel_fb_writer_if;

  logic                          fb_wr_en;
  logic [pixel_pkg::ADDR_W-1:0]  fb_addr;
  logic [pixel_pkg::COL_W-1:0]   fb_data;
  logic                          fb_ready;

  modport master (output fb_wr_en, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_wr_en, input fb_addr, input fb_data, output fb_ready);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding pending framebuffer writes.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   push, wdata   : write an entry (caller only pushes when not full, or
//                   when full and popping in the same cycle)
//   pop           : discard the head entry (caller only pops when not empty)
//   rdata         : current head entry (first-word fall-through)
//   full, empty   : occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      resetn,
  input  logic      push,
  input  logic      pop,
  input  fb_entry_t wdata,
  output fb_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  fb_entry_t   mem [DEPTH];

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pixel_fb_writer.sv
// Receives the draw controller's pixel-plot stream, range-checks each pixel,
// converts (x,y) to a linear framebuffer address, buffers the writes in a
// FIFO and drains them to the framebuffer under backpressure. On frame_end
// it waits until every pixel of the frame is written, then pulses
// frame_flushed and clears the sticky overflow flag.
// Ports:
//   clock, resetn      : clock, asynchronous active-low reset
//   plot, x, y, colour : one-cycle pixel strobe with its coordinates/colour
//   frame_end          : one-cycle pulse, last pixel of the frame issued
//   fb                 : framebuffer write port (master side)
//   fifo_full          : FIFO holds DEPTH entries
//   overflow           : sticky, an in-range pixel was dropped on a full FIFO
//   frame_flushed      : one-cycle pulse, frame fully written
//   dbg_state          : current flush controller state
//   clip_count         : out-of-range plot counter, only when the
//                        PIXEL_CLIP_COUNT_EN macro is defined
module pixel_fb_writer
  import pixel_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               plot,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [COL_W-1:0]   colour,
  input  logic               frame_end,
  pixel_fb_writer_if.master  fb,
  output logic               fifo_full,
  output logic               overflow,
  output logic               frame_flushed,
  output fsm_state_t         dbg_state
`ifdef PIXEL_CLIP_COUNT_EN
  ,
  output logic [15:0]        clip_count
`endif
);

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  // Stage 1: registered capture of the plot strobe.
  logic             in_range;
  logic             valid1;
  logic [X_W-1:0]   x1;
  logic [Y_W-1:0]   y1;
  logic [COL_W-1:0] col1;

  assign in_range = (x < X_LIM) && (y < Y_LIM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid1 <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      col1   <= '0;
    end else begin
      valid1 <= plot && in_range;
      if (plot) begin
        x1   <= x;
        y1   <= y;
        col1 <= colour;
      end
    end
  end

  // Stage 2: push into the FIFO. A pop in the same cycle frees a slot, so a
  // full FIFO still accepts the new pixel when the framebuffer is taking one.
  fb_entry_t wentry;
  fb_entry_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      drop;

  always_comb begin
    wentry        = '0;
    wentry.addr   = lin_addr(x1, y1);
    wentry.colour = col1;
  end

  assign pop  = !empty && fb.fb_ready;
  assign push = valid1 && (!full || pop);
  assign drop = valid1 && full && !pop;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (wentry),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // Head is masked while empty so the port idles at zero.
  assign fb.fb_wr_en = !empty;
  assign fb.fb_addr  = empty ? '0 : head.addr;
  assign fb.fb_data  = empty ? '0 : head.colour;
  assign fifo_full   = full;

  // Flush controller. Pixels keep flowing in every state; the controller only
  // watches for the pipeline and FIFO to go quiet after frame_end.
  fsm_state_t state;
  fsm_state_t next_state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    frame_flushed = 1'b0;
    case (state)
      IDLE: begin
        if (frame_end) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (!valid1 && empty && !push) begin
          next_state = DONE;
        end
      end
      DONE: begin
        frame_flushed = 1'b1;
        next_state    = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (state == DONE) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef PIXEL_CLIP_COUNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clip_count <= '0;
    end else if (state == DONE) begin
      clip_count <= '0;
    end else if (plot && !in_range && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule
